// File: rtl/conv_window_feeder.sv
// conv_window_feeder: buffers KSIZE+1 raster lines and replays each KSIZE-row band column-major.
// Optional end-of-frame out_rd pulse is enabled by defining FEEDER_RDPULSE_EN.
module conv_window_feeder #(
    parameter int unsigned DW    = 16,
    parameter int unsigned KSIZE = 3,
    parameter int unsigned IMG_W = 25,
    parameter int unsigned IMG_H = 25
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          frame_start,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic          acc_full,
    output logic [DW-1:0] out_data,
    output logic          out_wr,
    output logic          out_newline,
    output logic          busy,
`ifdef FEEDER_RDPULSE_EN
    output logic          out_rd,
`endif
    output logic          frame_done
);

    localparam int unsigned NBUF  = KSIZE + 1;
    localparam int unsigned DEPTH = NBUF * IMG_W;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned BW    = $clog2(NBUF);
    localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned JW    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int unsigned RW    = $clog2(IMG_H + 1);
    localparam int unsigned OW    = $clog2(IMG_H - KSIZE + 2);
    localparam int unsigned MW    = $clog2(IMG_H + KSIZE + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_EMIT_FIRST,
        S_EMIT_COL,
        S_NEWLINE,
        S_RDPULSE,
        S_DONE
    } state_t;

`ifdef FEEDER_RDPULSE_EN
    localparam state_t END_STATE = S_RDPULSE;
`else
    localparam state_t END_STATE = S_DONE;
`endif

    state_t          r_state;
    state_t          w_next;

    logic [RW-1:0]   r_wr_row;
    logic [CW-1:0]   r_wr_col;
    logic [BW-1:0]   r_wr_buf;
    logic [OW-1:0]   r_out_row;
    logic [BW-1:0]   r_rd_base;
    logic [CW-1:0]   r_col;
    logic [JW-1:0]   r_j;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [DW-1:0]   r_q;

    logic [CW-1:0]   w_nxt_col;
    logic [JW-1:0]   w_nxt_j;
    logic [BW:0]     w_rd_sum;
    logic [BW-1:0]   w_rd_buf;
    logic [AW-1:0]   w_rd_addr;
    logic [AW-1:0]   w_wr_addr;
    logic            w_emit;
    logic            w_wr_fire;
    logic            w_nl_fire;
    logic            w_rdp_fire;
    logic            w_pix_acc;
    logic            w_last_j;
    logic            w_last_first;
    logic            w_last_col;
    logic            w_last_band;
    logic            w_band_ready;
    logic            w_room;

    assign w_emit       = (r_state == S_EMIT_FIRST) || (r_state == S_EMIT_COL);
    assign w_wr_fire    = out_wr;
    assign w_nl_fire    = out_newline;
`ifdef FEEDER_RDPULSE_EN
    assign w_rdp_fire   = out_rd;
`else
    assign w_rdp_fire   = 1'b0;
`endif
    assign w_pix_acc    = pix_valid & pix_ready;
    assign w_last_j     = (r_j == JW'(KSIZE - 1));
    assign w_last_first = w_last_j && (r_col == CW'(KSIZE - 1));
    assign w_last_col   = w_last_j && (r_col == CW'(IMG_W - 1));
    assign w_last_band  = (r_out_row == OW'(IMG_H - KSIZE));
    assign w_band_ready = MW'(r_wr_row) >= (MW'(r_out_row) + MW'(KSIZE));
    assign w_room       = (MW'(r_wr_row) < (MW'(r_out_row) + MW'(NBUF))) &&
                          (r_wr_row < RW'(IMG_H));

    // Read address follows the pointer the next cycle will present, so the
    // registered RAM output always equals the pending word, stalled or not.
    always_comb begin
        w_nxt_col = r_col;
        w_nxt_j   = r_j;
        if (!w_emit || frame_start) begin
            w_nxt_col = '0;
            w_nxt_j   = '0;
        end else if (w_wr_fire) begin
            if (w_last_j) begin
                w_nxt_j   = '0;
                w_nxt_col = w_last_col ? '0 : r_col + CW'(1);
            end else begin
                w_nxt_j = r_j + JW'(1);
            end
        end
    end

    assign w_rd_sum  = {1'b0, r_rd_base} + (BW+1)'(w_nxt_j);
    assign w_rd_buf  = (w_rd_sum >= (BW+1)'(NBUF)) ? BW'(w_rd_sum - (BW+1)'(NBUF)) : BW'(w_rd_sum);
    assign w_rd_addr = AW'(32'(w_rd_buf) * IMG_W + 32'(w_nxt_col));
    assign w_wr_addr = AW'(32'(r_wr_buf) * IMG_W + 32'(r_wr_col));

    always_ff @(posedge Clk) begin
        if (w_pix_acc) begin
            r_mem[w_wr_addr] <= pix_in;
        end
        r_q <= r_mem[w_rd_addr];
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_wr_row  <= '0;
            r_wr_col  <= '0;
            r_wr_buf  <= '0;
            r_out_row <= '0;
            r_rd_base <= '0;
            r_col     <= '0;
            r_j       <= '0;
        end else begin
            r_col <= w_nxt_col;
            r_j   <= w_nxt_j;
            if (frame_start) begin
                r_wr_row  <= '0;
                r_wr_col  <= '0;
                r_wr_buf  <= '0;
                r_out_row <= '0;
                r_rd_base <= '0;
            end else begin
                if (w_pix_acc) begin
                    if (r_wr_col == CW'(IMG_W - 1)) begin
                        r_wr_col <= '0;
                        r_wr_row <= r_wr_row + RW'(1);
                        r_wr_buf <= (r_wr_buf == BW'(NBUF - 1)) ? '0 : r_wr_buf + BW'(1);
                    end else begin
                        r_wr_col <= r_wr_col + CW'(1);
                    end
                end
                if (w_nl_fire) begin
                    r_out_row <= r_out_row + OW'(1);
                    r_rd_base <= (r_rd_base == BW'(NBUF - 1)) ? '0 : r_rd_base + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (frame_start) begin
            w_next = S_RUN;
        end else begin
            case (r_state)
                S_IDLE:       w_next = S_IDLE;
                S_RUN:        if (w_band_ready) w_next = S_EMIT_FIRST;
                S_EMIT_FIRST: if (w_wr_fire && w_last_first)
                                  w_next = (IMG_W == KSIZE) ? S_NEWLINE : S_EMIT_COL;
                S_EMIT_COL:   if (w_wr_fire && w_last_col) w_next = S_NEWLINE;
                S_NEWLINE:    if (w_nl_fire) w_next = w_last_band ? END_STATE : S_RUN;
                S_RDPULSE:    if (w_rdp_fire) w_next = S_DONE;
                S_DONE:       w_next = S_IDLE;
                default:      w_next = S_IDLE;
            endcase
        end
    end

    // frame_start gates every strobe so an aborted cycle neither emits nor accepts.
    always_comb begin
        pix_ready   = 1'b0;
        out_wr      = 1'b0;
        out_newline = 1'b0;
        out_data    = '0;
        busy        = 1'b0;
        frame_done  = 1'b0;
`ifdef FEEDER_RDPULSE_EN
        out_rd      = 1'b0;
`endif
        case (r_state)
            S_RUN: begin
                busy      = 1'b1;
                pix_ready = w_room & ~frame_start;
            end
            S_EMIT_FIRST, S_EMIT_COL: begin
                busy      = 1'b1;
                pix_ready = w_room & ~frame_start;
                out_wr    = ~acc_full & ~frame_start;
                out_data  = r_q;
            end
            S_NEWLINE: begin
                busy        = 1'b1;
                pix_ready   = w_room & ~frame_start;
                out_newline = ~acc_full & ~frame_start;
            end
            S_RDPULSE: begin
                busy     = 1'b1;
                out_data = '1;
`ifdef FEEDER_RDPULSE_EN
                out_rd   = ~acc_full & ~frame_start;
`endif
            end
            S_DONE: begin
                frame_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
